// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and constants for the branch-predictor renew scheduler
//
// Purpose: FSM state encoding, queued update-entry record and the statistics
//          saturation value, shared by bp_renew_fifo and bp_renew_scheduler.
// Contents:
//   bp_state_t  S_RUN / S_SWEEP / S_DONE
//   bp_entry_t  {addr, taken, pred}; addr is held at BP_MAX_AW bits so the
//               record stays fixed-width for any LOW_ADDR_WIDTH up to 16
//   STAT_MAX    saturation value of the optional statistics counters
package bp_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } bp_state_t;

  localparam int BP_MAX_AW = 16;

  typedef struct packed {
    logic [BP_MAX_AW-1:0] addr;
    logic                 taken;
    logic                 pred;
  } bp_entry_t;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/bp_renew_fifo.sv
// rtl/bp_renew_fifo.sv - in-order pending-update FIFO with synchronous flush
//
// Purpose: holds resolved-branch updates until the scheduler issues them.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_push       write i_data at the tail (ignored when full or flushing)
//   i_data       entry to write
//   i_pop        drop the head entry (ignored when empty or flushing)
//   i_flush      empty the FIFO at the next edge; beats push and pop
//   o_head       current head entry, valid while !o_empty
//   o_empty      no entries held
//   o_full       DEPTH entries held
module bp_renew_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  bp_entry_t i_data,
  input  logic      i_pop,
  input  logic      i_flush,
  output bp_entry_t o_head,
  output logic      o_empty,
  output logic      o_full
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit: equal low bits with differing MSB means full.
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  bp_entry_t   r_mem [DEPTH];
  logic        w_push;
  logic        w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/bp_renew_scheduler.sv
// rtl/bp_renew_scheduler.sv - sequences the local branch predictor renew port
//
// Purpose: queues resolved branches, issues at most one renew per cycle,
//          defers a renew colliding with a same-address lookup for at most
//          STALL_LIMIT cycles, and runs a full-table clear sweep on request.
// Optional: BP_RENEW_STATS_EN adds stat_issued / stat_mispred counters.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   resolve_valid/ready/addr/taken/pred  update handshake from execute
//   predict_valid/addr                 snooped fetch-side lookup
//   flush                              discard queued, not-yet-issued updates
//   sweep_req / sweep_busy / sweep_done  table clear request and status
//   renew_valid/addr/result, last_predict  registered renew port
//   stat_issued, stat_mispred          saturating counters (optional)
module bp_renew_scheduler
  import bp_pkg::*;
#(
  parameter int LOW_ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int STALL_LIMIT    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      resolve_valid,
  output logic                      resolve_ready,
  input  logic [LOW_ADDR_WIDTH-1:0] resolve_addr,
  input  logic                      resolve_taken,
  input  logic                      resolve_pred,
  input  logic                      predict_valid,
  input  logic [LOW_ADDR_WIDTH-1:0] predict_addr,
  input  logic                      flush,
  input  logic                      sweep_req,
  output logic                      sweep_busy,
  output logic                      sweep_done,
  output logic                      renew_valid,
  output logic [LOW_ADDR_WIDTH-1:0] renew_addr,
  output logic                      renew_result,
  output logic                      last_predict
`ifdef BP_RENEW_STATS_EN
  ,
  output logic [15:0]               stat_issued,
  output logic [15:0]               stat_mispred
`endif
);

  bp_state_t                 r_state;
  logic [3:0]                r_stall_cnt;
  logic [LOW_ADDR_WIDTH-1:0] r_sweep_cnt;

  bp_entry_t w_head;
  bp_entry_t w_in;
  logic      w_empty;
  logic      w_full;
  logic      w_in_run;
  logic      w_push;
  logic      w_pop;
  logic      w_conflict;
  logic      w_defer;
  logic      w_fifo_flush;

  assign w_in_run      = (r_state == S_RUN);
  assign resolve_ready = w_in_run && !w_full && !flush && !sweep_req;
  assign w_push        = resolve_valid && resolve_ready;
  assign w_in          = '{addr: BP_MAX_AW'(resolve_addr), taken: resolve_taken, pred: resolve_pred};

  // Defer only while under the stall budget; at the budget the head is forced out.
  assign w_conflict = predict_valid && !w_empty && (w_head.addr == BP_MAX_AW'(predict_addr));
  assign w_defer    = w_conflict && (r_stall_cnt < 4'(STALL_LIMIT));
  assign w_pop      = w_in_run && !w_empty && !w_defer && !flush && !sweep_req;

  // Entering the sweep discards the queue; a coincident flush collapses into it.
  assign w_fifo_flush = flush || (w_in_run && sweep_req);

  bp_renew_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .i_flush (w_fifo_flush),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_RUN;
      r_stall_cnt  <= '0;
      r_sweep_cnt  <= '0;
      sweep_busy   <= 1'b0;
      sweep_done   <= 1'b0;
      renew_valid  <= 1'b0;
      renew_addr   <= '0;
      renew_result <= 1'b0;
      last_predict <= 1'b0;
    end else begin
      renew_valid <= 1'b0;
      sweep_done  <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (sweep_req) begin
            r_state     <= S_SWEEP;
            sweep_busy  <= 1'b1;
            r_sweep_cnt <= '0;
            r_stall_cnt <= '0;
          end else if (flush) begin
            r_stall_cnt <= '0;
          end else if (w_pop) begin
            renew_valid  <= 1'b1;
            renew_addr   <= w_head.addr[LOW_ADDR_WIDTH-1:0];
            renew_result <= w_head.taken;
            last_predict <= w_head.pred;
            r_stall_cnt  <= '0;
          end else if (w_defer) begin
            r_stall_cnt <= r_stall_cnt + 4'd1;
          end
        end
        S_SWEEP: begin
          renew_valid  <= 1'b1;
          renew_addr   <= r_sweep_cnt;
          renew_result <= 1'b0;
          last_predict <= 1'b0;
          if (r_sweep_cnt == {LOW_ADDR_WIDTH{1'b1}}) begin
            r_state     <= S_DONE;
            sweep_busy  <= 1'b0;
            sweep_done  <= 1'b1;
            r_sweep_cnt <= '0;
          end else begin
            r_sweep_cnt <= r_sweep_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

`ifdef BP_RENEW_STATS_EN
  // Counted at the edge that loads a queued entry into the renew registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued  <= '0;
      stat_mispred <= '0;
    end else if (w_pop) begin
      if (stat_issued != STAT_MAX) stat_issued <= stat_issued + 16'd1;
      if ((w_head.taken != w_head.pred) && (stat_mispred != STAT_MAX))
        stat_mispred <= stat_mispred + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_renew_scheduler.sv
// tb/tb_bp_renew_scheduler.sv - self-checking bench for bp_renew_scheduler
module tb_bp_renew_scheduler;

  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int SL    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          resolve_valid, resolve_ready, resolve_taken, resolve_pred;
  logic [AW-1:0] resolve_addr, predict_addr, renew_addr;
  logic          predict_valid, flush, sweep_req;
  logic          sweep_busy, sweep_done, renew_valid, renew_result, last_predict;
`ifdef BP_RENEW_STATS_EN
  logic [15:0]   stat_issued, stat_mispred;
`endif

  always #5 clk = ~clk;

  bp_renew_scheduler #(
    .LOW_ADDR_WIDTH (AW),
    .FIFO_DEPTH     (DEPTH),
    .STALL_LIMIT    (SL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .resolve_valid (resolve_valid),
    .resolve_ready (resolve_ready),
    .resolve_addr  (resolve_addr),
    .resolve_taken (resolve_taken),
    .resolve_pred  (resolve_pred),
    .predict_valid (predict_valid),
    .predict_addr  (predict_addr),
    .flush         (flush),
    .sweep_req     (sweep_req),
    .sweep_busy    (sweep_busy),
    .sweep_done    (sweep_done),
    .renew_valid   (renew_valid),
    .renew_addr    (renew_addr),
    .renew_result  (renew_result),
    .last_predict  (last_predict)
`ifdef BP_RENEW_STATS_EN
    ,
    .stat_issued   (stat_issued),
    .stat_mispred  (stat_mispred)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a queue of pending updates and a mode number.
  typedef struct {
    logic [AW-1:0] addr;
    logic          taken;
    logic          pred;
  } ent_t;

  ent_t          mq[$];
  int            m_stall, m_mode, m_idx;
  logic          m_valid, m_res, m_lp, m_busy, m_done;
  logic [AW-1:0] m_addr;
  logic          last_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_stall = 0; m_mode = 0; m_idx = 0;
    m_valid = 0; m_addr = '0; m_res = 0; m_lp = 0; m_busy = 0; m_done = 0;
  endtask

  function automatic logic model_ready();
    return (m_mode == 0) && (mq.size() < DEPTH) && !flush && !sweep_req;
  endfunction

  // Applies one clock edge of the specified behaviour using the current inputs.
  task automatic model_edge();
    logic rdy;
    ent_t e;
    rdy = model_ready();
    m_valid = 0;
    if (m_mode == 0) begin
      if (sweep_req) begin
        mq.delete(); m_stall = 0; m_mode = 1; m_idx = 0;
      end else if (flush) begin
        mq.delete(); m_stall = 0;
      end else begin
        if (mq.size() > 0) begin
          if (predict_valid && predict_addr == mq[0].addr && m_stall < SL) begin
            m_stall++;
          end else begin
            e = mq.pop_front();
            m_valid = 1; m_addr = e.addr; m_res = e.taken; m_lp = e.pred;
            m_stall = 0;
          end
        end
        if (resolve_valid && rdy)
          mq.push_back('{addr: resolve_addr, taken: resolve_taken, pred: resolve_pred});
      end
    end else if (m_mode == 1) begin
      m_valid = 1; m_addr = AW'(m_idx); m_res = 0; m_lp = 0;
      if (m_idx == (1 << AW) - 1) begin
        m_mode = 2; m_idx = 0;
      end else begin
        m_idx++;
      end
    end else begin
      m_mode = 0;
    end
    m_busy = (m_mode == 1);
    m_done = (m_mode == 2);
  endtask

  task automatic drive(input logic rv, input logic [AW-1:0] ra, input logic rt, input logic rp,
                       input logic pv, input logic [AW-1:0] pa, input logic fl, input logic sr);
    resolve_valid = rv; resolve_addr = ra; resolve_taken = rt; resolve_pred = rp;
    predict_valid = pv; predict_addr = pa; flush = fl; sweep_req = sr;
  endtask

  task automatic idle();
    drive(0, '0, 0, 0, 0, '0, 0, 0);
  endtask

  // One cycle: check ready against the model, clock, check registered outputs.
  task automatic cyc();
    #1;
    last_ready = resolve_ready;
    check("ready", resolve_ready, model_ready());
    @(posedge clk);
    model_edge();
    #1;
    check("outputs", {renew_valid, renew_addr, renew_result, last_predict, sweep_busy, sweep_done},
                     {m_valid, m_addr, m_res, m_lp, m_busy, m_done});
  endtask

  typedef struct {
    logic          rv;
    logic [AW-1:0] ra;
    logic          rt, rp, pv;
    logic [AW-1:0] pa;
    logic          e_ready, e_valid;
    logic [AW-1:0] e_addr;
    logic          e_res, e_lp;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            exp_k, bad_at, done_cnt, quiet_bad;
    logic          saw_low, found;
    logic [AW-1:0] got[$];
    logic [AW-1:0] addr_set[3];
    addr_set[0] = 8'h10; addr_set[1] = 8'h11; addr_set[2] = 8'h12;

    // single update, then two conflict-bound runs proving the stall count restarts
    tbl[0]  = '{1, 8'h12, 1, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0};
    tbl[1]  = '{0, 8'h00, 0, 0, 0, 8'h00, 1, 1, 8'h12, 1, 0};
    tbl[2]  = '{0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 8'h12, 1, 0};
    tbl[3]  = '{1, 8'h40, 0, 1, 1, 8'h40, 1, 0, 8'h12, 1, 0};
    tbl[4]  = '{0, 8'h00, 0, 0, 1, 8'h40, 1, 0, 8'h12, 1, 0};
    tbl[5]  = '{0, 8'h00, 0, 0, 1, 8'h40, 1, 0, 8'h12, 1, 0};
    tbl[6]  = '{0, 8'h00, 0, 0, 1, 8'h40, 1, 0, 8'h12, 1, 0};
    tbl[7]  = '{0, 8'h00, 0, 0, 1, 8'h40, 1, 1, 8'h40, 0, 1};
    tbl[8]  = '{1, 8'h40, 1, 1, 1, 8'h40, 1, 0, 8'h40, 0, 1};
    tbl[9]  = '{0, 8'h00, 0, 0, 1, 8'h40, 1, 0, 8'h40, 0, 1};
    tbl[10] = '{0, 8'h00, 0, 0, 1, 8'h40, 1, 0, 8'h40, 0, 1};
    tbl[11] = '{0, 8'h00, 0, 0, 1, 8'h40, 1, 0, 8'h40, 0, 1};
    tbl[12] = '{0, 8'h00, 0, 0, 1, 8'h40, 1, 1, 8'h40, 1, 1};
    tbl[13] = '{0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 8'h40, 1, 1};

    // reset state
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {resolve_ready, renew_valid, renew_addr, renew_result, last_predict, sweep_busy, sweep_done},
                         {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;
    model_reset();

    // table-driven vectors
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rv, tbl[i].ra, tbl[i].rt, tbl[i].rp, tbl[i].pv, tbl[i].pa, 0, 0);
      cyc();
      check($sformatf("vec%0d_ready", i), last_ready, tbl[i].e_ready);
      check($sformatf("vec%0d_renew", i), {renew_valid, renew_addr, renew_result, last_predict},
                                          {tbl[i].e_valid, tbl[i].e_addr, tbl[i].e_res, tbl[i].e_lp});
    end

    // back-to-back pushes without conflicts: ready stays high, order preserved
    saw_low = 0;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      if (i < 5) drive(1, AW'(i + 1), 1, 1, 0, '0, 0, 0);
      else       idle();
      cyc();
      if (i < 5 && !last_ready) saw_low = 1;
      if (renew_valid) got.push_back(renew_addr);
    end
    check("b2b_ready_low", saw_low, 0);
    check("b2b_count", got.size(), 5);
    for (int i = 0; i < got.size() && i < 5; i++) check($sformatf("b2b_order%0d", i), got[i], i + 1);

    // continuous conflict lets the queue fill: ready must drop
    saw_low = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 8'h55, 0, 0, 1, 8'h55, 0, 0);
      cyc();
      if (!last_ready) saw_low = 1;
    end
    check("full_ready_low", saw_low, 1);
    for (int i = 0; i < 12; i++) begin
      idle();
      cyc();
    end

    // flush race: three queued entries, flush together with a push
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'h77, 1, 0, 1, 8'h77, 0, 0);
      cyc();
    end
    drive(1, 8'h99, 1, 1, 1, 8'h77, 1, 0);
    cyc();
    check("flush_ready", last_ready, 0);
    quiet_bad = 0;
    for (int i = 0; i < 6; i++) begin
      idle();
      cyc();
      if (i == 0) check("flush_ready_after", last_ready, 1);
      if (renew_valid) quiet_bad++;
    end
    check("flush_no_renew", quiet_bad, 0);

    // sweep with a non-empty queue and a coincident flush
    for (int i = 0; i < 2; i++) begin
      drive(1, 8'h33, 1, 0, 1, 8'h33, 0, 0);
      cyc();
    end
    drive(0, '0, 0, 0, 1, 8'h00, 1, 1);
    cyc();
    exp_k = 0; bad_at = -1; done_cnt = 0;
    for (int i = 0; i < 265; i++) begin
      drive(0, '0, 0, 0, 1, AW'(i + 1), 0, 0);
      cyc();
      if (renew_valid) begin
        if ((renew_addr !== AW'(exp_k) || renew_result !== 1'b0) && bad_at < 0) bad_at = exp_k;
        exp_k++;
      end
      if (sweep_done) done_cnt++;
    end
    check("sweep_count", exp_k, 256);
    check("sweep_order", bad_at, -1);
    check("sweep_done_pulses", done_cnt, 1);

    // randomized run against the model
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 1), addr_set[$urandom_range(0, 2)], $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), addr_set[$urandom_range(0, 2)],
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 299) == 0));
      cyc();
    end
    for (int i = 0; i < 270; i++) begin
      idle();
      cyc();
    end

    // reset in the middle of a sweep
    drive(0, '0, 0, 0, 0, '0, 0, 1);
    cyc();
    idle();
    found = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (renew_valid && renew_addr == 8'h05) begin
        found = 1;
        break;
      end
    end
    check("reach_addr5", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {resolve_ready, renew_valid, renew_addr, renew_result, last_predict, sweep_busy, sweep_done},
                         {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    drive(1, 8'hAB, 1, 0, 0, '0, 0, 0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      idle();
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
